rgb_stream_packer: RTL and testbench

//  Downstream stage of the fractal pixel generator. Takes one 24-bit RGB pixel per handshake
//  (r,g,b plus sof/eol flags) and packs 4 pixels into 3 32-bit AXI4-Stream words for the VDMA.

---
 rtl/rgb_stream_packer.sv | 159 +++++++++++++++
 tb/tb_rgb_stream_packer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_stream_packer.sv
// rgb_stream_packer: packs 24-bit RGB pixels (4 px -> 3 words, little-endian)
// into a 32-bit AXI4-Stream master with tuser=SOF and tlast=end-of-line.
module rgb_stream_packer #(
   parameter logic [7:0] PAD_BYTE    = 8'h00,
   parameter logic       SOF_REALIGN = 1'b1
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic [7:0]  r,
   input  logic [7:0]  g,
   input  logic [7:0]  b,
   input  logic        valid,
   input  logic        sof,
   input  logic        eol,
   output logic        in_stream_ready,
   output logic [31:0] out_stream_tdata,
   output logic [3:0]  out_stream_tkeep,
   output logic        out_stream_tlast,
   output logic        out_stream_tuser,
   output logic        out_stream_tvalid,
   input  logic        out_stream_tready,
   output logic        align_err
);

   typedef enum logic {PACK, FLUSH} state_t;

   state_t      state;
   logic [1:0]  phase;
   logic [23:0] left;
   logic        sof_pend;

   logic [23:0] pix;
   logic        out_free;
   logic        accept;
   logic [1:0]  eff_phase;

   logic        emit_vld;
   logic [31:0] emit_data;
   logic        emit_last;
   logic [23:0] next_left;
   logic [1:0]  next_phase;
   logic        go_flush;
   logic [31:0] flush_data;

   assign pix             = {r, g, b};
   assign out_free        = !out_stream_tvalid || out_stream_tready;
   assign in_stream_ready = (state == PACK) && out_free;
   assign accept          = valid && in_stream_ready;
   // A realigning sof restarts packing as if at phase 0, discarding leftover bytes
   assign eff_phase       = (SOF_REALIGN && sof) ? 2'd0 : phase;

   // Next word / leftover / phase for the pixel currently presented
   always_comb begin
      emit_vld   = 1'b0;
      emit_data  = '0;
      emit_last  = 1'b0;
      next_left  = left;
      next_phase = phase;
      go_flush   = 1'b0;
      case (eff_phase)
         2'd0: begin
            next_left  = pix;
            next_phase = 2'd1;
            if (eol) begin
               emit_vld   = 1'b1;
               emit_data  = {PAD_BYTE, pix};
               emit_last  = 1'b1;
               next_phase = 2'd0;
            end
         end
         2'd1: begin
            emit_vld   = 1'b1;
            emit_data  = {pix[7:0], left[23:0]};
            next_left  = {8'h00, pix[23:8]};
            next_phase = 2'd2;
            go_flush   = eol;
         end
         2'd2: begin
            emit_vld   = 1'b1;
            emit_data  = {pix[15:0], left[15:0]};
            next_left  = {16'h0000, pix[23:16]};
            next_phase = 2'd3;
            go_flush   = eol;
         end
         default: begin
            emit_vld   = 1'b1;
            emit_data  = {pix, left[7:0]};
            emit_last  = eol;
            next_phase = 2'd0;
         end
      endcase
   end

   // Flush word: leftover bytes in the low lanes, pad above (phase 2 holds 2 bytes, phase 3 holds 1)
   always_comb begin
      flush_data = {PAD_BYTE, PAD_BYTE, PAD_BYTE, left[7:0]};
      if (phase == 2'd2)
         flush_data = {PAD_BYTE, PAD_BYTE, left[15:0]};
   end

   // Packing FSM with the single registered output word
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state             <= PACK;
         phase             <= 2'd0;
         left              <= '0;
         sof_pend          <= 1'b0;
         align_err         <= 1'b0;
         out_stream_tvalid <= 1'b0;
         out_stream_tdata  <= '0;
         out_stream_tkeep  <= '0;
         out_stream_tlast  <= 1'b0;
         out_stream_tuser  <= 1'b0;
      end else begin
         align_err <= 1'b0;
         if (out_stream_tready) begin
            out_stream_tvalid <= 1'b0;
            out_stream_tkeep  <= '0;
         end
         case (state)
            PACK: begin
               if (accept) begin
                  left  <= next_left;
                  phase <= next_phase;
                  if (sof && (phase != 2'd0))
                     align_err <= 1'b1;
                  if (emit_vld) begin
                     out_stream_tvalid <= 1'b1;
                     out_stream_tkeep  <= 4'hF;
                     out_stream_tdata  <= emit_data;
                     out_stream_tlast  <= emit_last;
                     out_stream_tuser  <= sof_pend || sof;
                     sof_pend          <= 1'b0;
                  end else if (sof) begin
                     sof_pend <= 1'b1;
                  end
                  if (go_flush)
                     state <= FLUSH;
               end
            end
            FLUSH: begin
               if (out_free) begin
                  out_stream_tvalid <= 1'b1;
                  out_stream_tkeep  <= 4'hF;
                  out_stream_tdata  <= flush_data;
                  out_stream_tlast  <= 1'b1;
                  out_stream_tuser  <= sof_pend;
                  sof_pend          <= 1'b0;
                  phase             <= 2'd0;
                  left              <= '0;
                  state             <= PACK;
               end
            end
            default: state <= PACK;
         endcase
      end
   end

endmodule

// File: tb/tb_rgb_stream_packer.sv
// Directed self-checking bench for rgb_stream_packer.
module tb_rgb_stream_packer;

   logic        aclk = 1'b0;
   logic        areset;
   logic [7:0]  r, g, b;
   logic        valid, sof, eol;
   logic        in_stream_ready;
   logic [31:0] out_stream_tdata;
   logic [3:0]  out_stream_tkeep;
   logic        out_stream_tlast, out_stream_tuser, out_stream_tvalid;
   logic        out_stream_tready;
   logic        align_err;

   rgb_stream_packer #(.PAD_BYTE(8'h00), .SOF_REALIGN(1'b1)) dut (
      .aclk              (aclk),
      .areset            (areset),
      .r                 (r),
      .g                 (g),
      .b                 (b),
      .valid             (valid),
      .sof               (sof),
      .eol               (eol),
      .in_stream_ready   (in_stream_ready),
      .out_stream_tdata  (out_stream_tdata),
      .out_stream_tkeep  (out_stream_tkeep),
      .out_stream_tlast  (out_stream_tlast),
      .out_stream_tuser  (out_stream_tuser),
      .out_stream_tvalid (out_stream_tvalid),
      .out_stream_tready (out_stream_tready),
      .align_err         (align_err)
   );

   always #5 aclk = ~aclk;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic        user;
      logic [3:0]  keep;
   } word_t;

   word_t q[$];
   int    n_pass  = 0;
   int    n_total = 0;
   int    cyc     = 0;

   always @(posedge aclk) cyc <= cyc + 1;

   // Record each word at the negedge before the handshake edge
   always @(negedge aclk)
      if (!areset && out_stream_tvalid && out_stream_tready)
         q.push_back('{data: out_stream_tdata, last: out_stream_tlast,
                       user: out_stream_tuser, keep: out_stream_tkeep});

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
   endtask

   task automatic send(input logic [23:0] p, input logic s, input logic e);
      bit acc = 0;
      {r, g, b} = p;
      valid = 1'b1;
      sof   = s;
      eol   = e;
      for (int n = 0; n < 100; n++) begin
         @(negedge aclk);
         if (in_stream_ready) begin
            acc = 1;
            break;
         end
      end
      @(posedge aclk);
      #1;
      valid = 1'b0;
      sof   = 1'b0;
      eol   = 1'b0;
      if (!acc) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic expect_word(input string tag, input logic [31:0] d, input logic l, input logic u);
      word_t w;
      bit    got = 0;
      for (int n = 0; n < 50; n++) begin
         if (q.size() > 0) begin
            got = 1;
            break;
         end
         @(posedge aclk);
         #2;
      end
      if (!got) begin
         chk({tag, "_timeout"}, 32'd0, 32'd1);
      end else begin
         w = q.pop_front();
         chk({tag, "_data"}, w.data, d);
         chk({tag, "_last"}, {31'd0, w.last}, {31'd0, l});
         chk({tag, "_user"}, {31'd0, w.user}, {31'd0, u});
         chk({tag, "_keep"}, {28'd0, w.keep}, 32'hF);
      end
   endtask

   initial begin
      logic [31:0] held;
      logic [23:0] px;
      logic [7:0]  bytes [0:1919];
      int          c0, bad_data, bad_flags;
      word_t       w;

      areset = 1'b1;
      valid = 1'b0; sof = 1'b0; eol = 1'b0; {r, g, b} = '0;
      out_stream_tready = 1'b1;
      repeat (2) @(posedge aclk);
      #1;
      chk("rst_tvalid", {31'd0, out_stream_tvalid}, 32'd0);
      chk("rst_tdata", out_stream_tdata, 32'd0);
      chk("rst_tkeep", {28'd0, out_stream_tkeep}, 32'd0);
      chk("rst_align", {31'd0, align_err}, 32'd0);
      chk("rst_ready", {31'd0, in_stream_ready}, 32'd1);
      @(negedge aclk);
      areset = 1'b0;
      @(posedge aclk);
      #1;

      // Four pixels at full rate
      c0 = cyc;
      send(24'h010203, 0, 0);
      send(24'h040506, 0, 0);
      send(24'h070809, 0, 0);
      send(24'h0A0B0C, 0, 0);
      chk("t1_rate", cyc - c0, 32'd4);
      expect_word("t1_w0", 32'h06010203, 0, 0);
      expect_word("t1_w1", 32'h08090405, 0, 0);
      expect_word("t1_w2", 32'h0A0B0C07, 0, 0);

      // Full 640-pixel line, checked against a little-endian byte stream
      for (int i = 0; i < 640; i++) begin
         px = {8'(i) ^ 8'hA5, 8'(i >> 8), 8'(i)};
         bytes[3*i]   = px[7:0];
         bytes[3*i+1] = px[15:8];
         bytes[3*i+2] = px[23:16];
      end
      c0 = cyc;
      for (int i = 0; i < 640; i++) begin
         px = {8'(i) ^ 8'hA5, 8'(i >> 8), 8'(i)};
         send(px, i == 0, i == 639);
      end
      chk("t2_cycles", cyc - c0, 32'd640);
      repeat (3) @(posedge aclk);
      #2;
      chk("t2_count", q.size(), 32'd480);
      bad_data = 0;
      bad_flags = 0;
      for (int k = 0; k < 480 && q.size() > 0; k++) begin
         w = q.pop_front();
         if (w.data !== {bytes[4*k+3], bytes[4*k+2], bytes[4*k+1], bytes[4*k]}) bad_data++;
         if (k == 0) chk("t2_w0_user", {31'd0, w.user}, 32'd1);
         else if (w.user !== 1'b0) bad_flags++;
         if (k == 479) chk("t2_w479_last", {31'd0, w.last}, 32'd1);
         else if (w.last !== 1'b0) bad_flags++;
      end
      chk("t2_bad_data", bad_data, 32'd0);
      chk("t2_bad_flags", bad_flags, 32'd0);

      // Back-pressure: output held five cycles
      out_stream_tready = 1'b0;
      send(24'h112233, 0, 0);
      send(24'h445566, 0, 0);
      held = out_stream_tdata;
      chk("t3_held_val", held, 32'h66112233);
      for (int n = 0; n < 5; n++) begin
         @(negedge aclk);
         chk("t3_stable", out_stream_tdata, held);
         chk("t3_tvalid", {31'd0, out_stream_tvalid}, 32'd1);
         chk("t3_ready", {31'd0, in_stream_ready}, 32'd0);
         chk("t3_flags", {30'd0, out_stream_tlast, out_stream_tuser}, 32'd0);
      end
      @(posedge aclk);
      #1;
      out_stream_tready = 1'b1;
      send(24'h778899, 0, 0);
      send(24'hAABBCC, 0, 1);
      expect_word("t3_w0", 32'h66112233, 0, 0);
      expect_word("t3_w1", 32'h88994455, 0, 0);
      expect_word("t3_w2", 32'hAABBCC77, 1, 0);
      repeat (3) @(posedge aclk);
      #2;
      chk("t3_no_dup", q.size(), 32'd0);

      // eol at phase 1 forces a flush word
      send(24'hC0FFEE, 0, 0);
      send(24'h123456, 0, 1);
      chk("t4_flush_ready0", {31'd0, in_stream_ready}, 32'd0);
      @(posedge aclk);
      #1;
      chk("t4_ready_back", {31'd0, in_stream_ready}, 32'd1);
      expect_word("t4_w0", 32'h56C0FFEE, 0, 0);
      expect_word("t4_flush", 32'h00001234, 1, 0);

      // eol at phase 0 and at phase 2
      send(24'hABCDEF, 0, 1);
      expect_word("t4_ph0", 32'h00ABCDEF, 1, 0);
      send(24'h102030, 0, 0);
      send(24'h405060, 0, 0);
      send(24'h708090, 0, 1);
      expect_word("t4_ph2_w0", 32'h60102030, 0, 0);
      expect_word("t4_ph2_w1", 32'h80904050, 0, 0);
      expect_word("t4_ph2_flush", 32'h00000070, 1, 0);

      // sof arriving at phase 2 realigns
      send(24'h0F0E0D, 0, 0);
      send(24'h0C0B0A, 0, 0);
      send(24'h5A5A01, 1, 0);
      chk("t5_align_pulse", {31'd0, align_err}, 32'd1);
      @(posedge aclk);
      #1;
      chk("t5_align_clear", {31'd0, align_err}, 32'd0);
      send(24'h000102, 0, 0);
      send(24'h030405, 0, 0);
      send(24'h060708, 0, 1);
      expect_word("t5_w0", 32'h0A0F0E0D, 0, 0);
      expect_word("t5_w1", 32'h025A5A01, 0, 1);
      expect_word("t5_w2", 32'h04050001, 0, 0);
      expect_word("t5_w3", 32'h06070803, 1, 0);

      // sof and eol together at phase 0
      send(24'h998877, 1, 1);
      expect_word("t5_sof_eol", 32'h00998877, 1, 1);

      // Reset while a word is held and phase is 2
      out_stream_tready = 1'b0;
      send(24'hDEAD01, 0, 0);
      send(24'hBEEF02, 0, 0);
      chk("t6_pre_tvalid", {31'd0, out_stream_tvalid}, 32'd1);
      #2;
      areset = 1'b1;
      #1;
      chk("t6_tvalid_drop", {31'd0, out_stream_tvalid}, 32'd0);
      chk("t6_tkeep_drop", {28'd0, out_stream_tkeep}, 32'd0);
      @(negedge aclk);
      areset = 1'b0;
      q.delete();
      out_stream_tready = 1'b1;
      @(posedge aclk);
      #1;
      send(24'h010203, 0, 0);
      send(24'h040506, 0, 0);
      send(24'h070809, 0, 0);
      send(24'h0A0B0C, 0, 0);
      expect_word("t6_w0", 32'h06010203, 0, 0);
      expect_word("t6_w1", 32'h08090405, 0, 0);
      expect_word("t6_w2", 32'h0A0B0C07, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
